// File: rtl/rd_axi_master_if.sv
// AXI read-channel bundle (AR + R) between the DDR read master and the memory slave.
interface rd_axi_master_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DQ_WIDTH   = 32
);
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic [3:0]            axi_arid;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [8*DQ_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_araddr, axi_arlen, axi_arid, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_araddr, axi_arlen, axi_arid, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/rd_axi_master.sv
// DDR read request front-end: splits a (start, length) request into AXI read bursts
// and streams the returned beats out with a one-cycle registered latency.
//
// state | meaning
// IDLE  | waiting for a valid active slot
// ADDR  | AR presented, held until arready
// DATA  | accepting R beats of the current burst
// DONE  | pulse ddr_rdone, free active slot, promote pending slot
module rd_axi_master #(
  parameter int         ADDR_WIDTH = 27,
  parameter int         DQ_WIDTH   = 32,
  parameter int         LEN_WIDTH  = 16,
  parameter int         BURST_MAX  = 16,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rst,
  input  logic                  ddr_rreq,
  input  logic [ADDR_WIDTH-1:0] ddr_raddr,
  input  logic [LEN_WIDTH-1:0]  ddr_rd_len,
  output logic [8*DQ_WIDTH-1:0] ddr_rdata,
  output logic                  ddr_rdata_en,
  output logic                  ddr_rdone,
  output logic                  req_ovf,
  output logic                  rd_err,
  rd_axi_master_if.master       axi
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP   = ADDR_WIDTH'(8);
  localparam logic [LEN_WIDTH:0]    BURST_MAX_W = (LEN_WIDTH+1)'(BURST_MAX);

  state_t                state_q, state_d;
  logic                  act_valid_q, act_valid_d;
  logic [ADDR_WIDTH-1:0] act_addr_q, act_addr_d;
  logic [LEN_WIDTH-1:0]  act_len_q, act_len_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [LEN_WIDTH-1:0]  pend_len_q, pend_len_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  rready_q, rready_d;
  logic                  rdone_q, rdone_d;
  logic [8*DQ_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_en_q, rdata_en_d;
  logic                  req_ovf_q, req_ovf_d;
  logic                  rd_err_q, rd_err_d;
  logic                  beat_fire;

  function automatic logic [7:0] burst_arlen(input logic [LEN_WIDTH-1:0] rem);
    logic [LEN_WIDTH:0] beats;
    beats = ({1'b0, rem} > BURST_MAX_W) ? BURST_MAX_W : {1'b0, rem};
    beats = beats - (LEN_WIDTH+1)'(1);
    return 8'(beats);
  endfunction

  assign beat_fire = axi.axi_rvalid && rready_q;

  always_comb begin
    state_d      = state_q;
    act_valid_d  = act_valid_q;
    act_addr_d   = act_addr_q;
    act_len_d    = act_len_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_len_d   = pend_len_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    rready_d     = rready_q;
    rdone_d      = 1'b0;
    req_ovf_d    = req_ovf_q;
    rdata_en_d   = beat_fire;
    rdata_d      = beat_fire ? axi.axi_rdata : rdata_q;
    rd_err_d     = rd_err_q | (beat_fire && (axi.axi_rresp != 2'b00));

    case (state_q)
      IDLE: begin
        if (act_valid_q) begin
          cur_addr_d  = act_addr_q;
          remaining_d = act_len_q;
          if (act_len_q != '0) begin
            state_d   = ADDR;
            arvalid_d = 1'b1;
            araddr_d  = act_addr_q;
            arlen_d   = burst_arlen(act_len_q);
          end else begin
            state_d = DONE;
          end
        end
      end
      ADDR: begin
        if (axi.axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          cur_addr_d  = cur_addr_q + BEAT_STEP;
          remaining_d = (remaining_q != '0) ? remaining_q - LEN_WIDTH'(1) : '0;
          // rlast always closes the burst; any shortfall rolls into the next AR
          if (axi.axi_rlast) begin
            rready_d = 1'b0;
            if (remaining_d != '0) begin
              state_d   = ADDR;
              arvalid_d = 1'b1;
              araddr_d  = cur_addr_d;
              arlen_d   = burst_arlen(remaining_d);
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        rdone_d      = 1'b1;
        act_valid_d  = pend_valid_q;
        act_addr_d   = pend_addr_q;
        act_len_d    = pend_len_q;
        pend_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Intake sees the slots after any DONE promotion in the same cycle
    if (ddr_rreq) begin
      if (!act_valid_d) begin
        act_valid_d = 1'b1;
        act_addr_d  = ddr_raddr;
        act_len_d   = ddr_rd_len;
      end else if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = ddr_raddr;
        pend_len_d   = ddr_rd_len;
      end else begin
        req_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q      <= IDLE;
      act_valid_q  <= 1'b0;
      act_addr_q   <= '0;
      act_len_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_len_q   <= '0;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      rready_q     <= 1'b0;
      rdone_q      <= 1'b0;
      rdata_q      <= '0;
      rdata_en_q   <= 1'b0;
      req_ovf_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_valid_q  <= act_valid_d;
      act_addr_q   <= act_addr_d;
      act_len_q    <= act_len_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_len_q   <= pend_len_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      rready_q     <= rready_d;
      rdone_q      <= rdone_d;
      rdata_q      <= rdata_d;
      rdata_en_q   <= rdata_en_d;
      req_ovf_q    <= req_ovf_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign ddr_rdata       = rdata_q;
  assign ddr_rdata_en    = rdata_en_q;
  assign ddr_rdone       = rdone_q;
  assign req_ovf         = req_ovf_q;
  assign rd_err          = rd_err_q;
  assign axi.axi_araddr  = araddr_q;
  assign axi.axi_arlen   = arlen_q;
  assign axi.axi_arid    = AXI_ID;
  assign axi.axi_arvalid = arvalid_q;
  assign axi.axi_rready  = rready_q;

endmodule

// File: tb/tb_rd_axi_master.sv
// Scoreboard bench for rd_axi_master: an AXI slave model serves bursts, expected ARs,
// beats and completions are queued at request time and checked as the DUT produces them.
module tb_rd_axi_master;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int BMAX = 16;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [8*DW-1:0] data; int tag; } beat_t;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst = 1'b1;
  logic          ddr_rreq = 1'b0;
  logic [AW-1:0] ddr_raddr = '0;
  logic [LW-1:0] ddr_rd_len = '0;
  logic [8*DW-1:0] ddr_rdata;
  logic          ddr_rdata_en, ddr_rdone, req_ovf, rd_err;

  rd_axi_master_if #(.ADDR_WIDTH(AW), .DQ_WIDTH(DW)) axi_bus ();

  rd_axi_master #(.ADDR_WIDTH(AW), .DQ_WIDTH(DW), .LEN_WIDTH(LW), .BURST_MAX(BMAX), .AXI_ID(4'd0)) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .ddr_rreq(ddr_rreq), .ddr_raddr(ddr_raddr),
    .ddr_rd_len(ddr_rd_len), .ddr_rdata(ddr_rdata), .ddr_rdata_en(ddr_rdata_en),
    .ddr_rdone(ddr_rdone), .req_ovf(req_ovf), .rd_err(rd_err), .axi(axi_bus)
  );

  always #5 ddr_clk = ~ddr_clk;

  ar_t   exp_ar_q[$];
  beat_t exp_beat_q[$];
  int    exp_done_q[$];
  ar_t   burst_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int next_tag = 0;
  bit mon_en = 1'b0;
  bit slave_flush = 1'b0;
  int ar_hold = 0;
  int ar_stall = 0;
  int short_beats = 0;
  int err_at = -1;
  int beat_cnt = 0;
  logic [8*DW-1:0] last_rdata = '0;

  function automatic logic [8*DW-1:0] beat_data(input logic [AW-1:0] a);
    logic [8*DW-1:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = {2'b01, a, 3'(k)};
    return d;
  endfunction

  task automatic push_req(input logic [AW-1:0] addr, input int len, input int tag);
    logic [AW-1:0] a;
    int rem, n;
    a = addr;
    rem = len;
    while (rem > 0) begin
      n = (rem > BMAX) ? BMAX : rem;
      exp_ar_q.push_back('{a, 8'(n - 1)});
      a = a + AW'(8 * n);
      rem -= n;
    end
    for (int i = 0; i < len; i++) exp_beat_q.push_back('{beat_data(addr + AW'(8 * i)), tag});
    exp_done_q.push_back(tag);
  endtask

  task automatic issue(input logic [AW-1:0] addr, input int len);
    @(negedge ddr_clk);
    ddr_rreq = 1'b1; ddr_raddr = addr; ddr_rd_len = LW'(len);
    @(negedge ddr_clk);
    ddr_rreq = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ddr_clk); #1;
      if (exp_done_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  // AR slave: optional stall, stability and expected-burst checks
  initial begin : ar_slave
    ar_t first, e;
    forever begin
      @(negedge ddr_clk);
      if (slave_flush) begin
        axi_bus.axi_arready = 1'b0; ar_stall = 0;
      end else if (axi_bus.axi_arready) begin
        axi_bus.axi_arready = 1'b0;
      end else if (axi_bus.axi_arvalid === 1'b1) begin
        if (ar_stall == 0) begin
          first.addr = axi_bus.axi_araddr; first.len = axi_bus.axi_arlen;
        end else begin
          n_checks++;
          if (axi_bus.axi_araddr !== first.addr || axi_bus.axi_arlen !== first.len)
            $display("FAIL ar_stable: araddr=%h arlen=%0d, required %h/%0d held", axi_bus.axi_araddr, axi_bus.axi_arlen, first.addr, first.len);
          else n_pass++;
        end
        if (ar_stall >= ar_hold) begin
          n_checks++;
          if (exp_ar_q.size() == 0)
            $display("FAIL ar_unexpected: araddr=%h arlen=%0d, required no AR", first.addr, first.len);
          else begin
            e = exp_ar_q.pop_front();
            if (first.addr !== e.addr || first.len !== e.len)
              $display("FAIL ar_burst: araddr=%h arlen=%0d, required %h/%0d", first.addr, first.len, e.addr, e.len);
            else n_pass++;
          end
          burst_q.push_back(first);
          axi_bus.axi_arready = 1'b1;
          ar_stall = 0;
        end else ar_stall++;
      end
    end
  end

  // R slave: beats with random gaps, optional early rlast and error response
  initial begin : r_slave
    ar_t cur;
    int idx, blen;
    bit active, prev_rready;
    active = 1'b0; prev_rready = 1'b0; idx = 0; blen = 0;
    forever begin
      @(negedge ddr_clk);
      if (slave_flush) begin
        burst_q.delete(); active = 1'b0; prev_rready = 1'b0;
        axi_bus.axi_rvalid = 1'b0; axi_bus.axi_rlast = 1'b0; axi_bus.axi_rresp = 2'b00;
      end else begin
        if (axi_bus.axi_rvalid && prev_rready) begin
          beat_cnt++;
          if (axi_bus.axi_rlast) active = 1'b0; else idx++;
        end
        if (!active && burst_q.size() > 0) begin
          cur = burst_q.pop_front(); idx = 0; blen = int'(cur.len) + 1;
          if (short_beats > 0) begin blen = short_beats; short_beats = 0; end
          active = 1'b1;
        end
        if (active && $urandom_range(0, 3) != 0) begin
          axi_bus.axi_rvalid = 1'b1;
          axi_bus.axi_rdata  = beat_data(cur.addr + AW'(8 * idx));
          axi_bus.axi_rlast  = (idx == blen - 1);
          axi_bus.axi_rresp  = (beat_cnt == err_at) ? 2'b10 : 2'b00;
        end else begin
          axi_bus.axi_rvalid = 1'b0; axi_bus.axi_rlast = 1'b0; axi_bus.axi_rresp = 2'b00;
        end
        prev_rready = axi_bus.axi_rready;
      end
    end
  end

  initial begin : data_mon
    beat_t b;
    forever begin
      @(negedge ddr_clk);
      if (mon_en) begin
        n_checks++;
        if (ddr_rdata_en === 1'b1) begin
          if (exp_beat_q.size() == 0)
            $display("FAIL rdata_unexpected: rdata=%h, required no beat", ddr_rdata);
          else begin
            b = exp_beat_q.pop_front();
            if (ddr_rdata !== b.data) $display("FAIL rdata_beat: got %h, required %h", ddr_rdata, b.data);
            else n_pass++;
            last_rdata = b.data;
          end
        end else if (ddr_rdata_en !== 1'b0 || ddr_rdata !== last_rdata)
          $display("FAIL rdata_hold: en=%b rdata=%h, required en=0 rdata=%h", ddr_rdata_en, ddr_rdata, last_rdata);
        else n_pass++;
      end
    end
  end

  initial begin : done_mon
    int t;
    forever begin
      @(negedge ddr_clk);
      if (mon_en && ddr_rdone === 1'b1) begin
        n_checks++;
        if (exp_done_q.size() == 0)
          $display("FAIL rdone_unexpected: got ddr_rdone=1, required no completion pending");
        else begin
          t = exp_done_q.pop_front();
          if (ddr_rdata_en !== 1'b0 || (exp_beat_q.size() != 0 && exp_beat_q[0].tag == t))
            $display("FAIL rdone_order: tag %0d rdata_en=%b beats_left=%0d, required rdone after all beats", t, ddr_rdata_en, exp_beat_q.size());
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge ddr_clk);
    #1;
    n_checks++;
    if ({axi_bus.axi_arvalid, axi_bus.axi_rready, ddr_rdata_en, ddr_rdone, req_ovf, rd_err} !== 6'b0)
      $display("FAIL reset_ctrl: arvalid/rready/en/rdone/ovf/err=%b, required 000000",
               {axi_bus.axi_arvalid, axi_bus.axi_rready, ddr_rdata_en, ddr_rdone, req_ovf, rd_err});
    else n_pass++;
    n_checks++;
    if (ddr_rdata !== '0) $display("FAIL reset_rdata: got %h, required 0", ddr_rdata); else n_pass++;
    n_checks++;
    if (axi_bus.axi_araddr !== '0 || axi_bus.axi_arlen !== 8'd0)
      $display("FAIL reset_ar: araddr=%h arlen=%0d, required 0/0", axi_bus.axi_araddr, axi_bus.axi_arlen);
    else n_pass++;
    n_checks++;
    if (axi_bus.axi_arid !== 4'd0) $display("FAIL reset_arid: got %0d, required 0", axi_bus.axi_arid); else n_pass++;
    ddr_rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_multi_burst();
    bit ok;
    int tag;
    tag = next_tag++;
    exp_ar_q.push_back('{27'h100, 8'd15});
    exp_ar_q.push_back('{27'h180, 8'd15});
    exp_ar_q.push_back('{27'h200, 8'd15});
    exp_ar_q.push_back('{27'h280, 8'd11});
    for (int i = 0; i < 60; i++) exp_beat_q.push_back('{beat_data(27'h100 + AW'(8 * i)), tag});
    exp_done_q.push_back(tag);
    issue(27'h100, 60);
    wait_done(600, ok);
    n_checks++;
    if (!ok || exp_ar_q.size() != 0) $display("FAIL multi_burst_done: pending done=%0d ar=%0d, required 0/0", exp_done_q.size(), exp_ar_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    bit ok, saw_ar;
    ok = 1'b0; saw_ar = 1'b0;
    push_req(27'h40, 0, next_tag++);
    issue(27'h40, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ddr_clk); #1;
      if (axi_bus.axi_arvalid === 1'b1) saw_ar = 1'b1;
      if (exp_done_q.size() == 0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || saw_ar) $display("FAIL zero_len: done_seen=%b arvalid_seen=%b, required 1/0", ok, saw_ar);
    else n_pass++;
  endtask

  task automatic test_ar_stall();
    bit ok;
    ar_hold = 20;
    push_req(27'h40, 8, next_tag++);
    issue(27'h40, 8);
    wait_done(300, ok);
    ar_hold = 0;
    n_checks++;
    if (!ok) $display("FAIL ar_stall_done: pending done=%0d, required 0", exp_done_q.size()); else n_pass++;
  endtask

  task automatic test_rresp_err();
    bit ok;
    n_checks++;
    if (rd_err !== 1'b0) $display("FAIL rd_err_clear: got %b, required 0", rd_err); else n_pass++;
    err_at = beat_cnt + 4;
    push_req(27'h800, 16, next_tag++);
    issue(27'h800, 16);
    wait_done(300, ok);
    err_at = -1;
    n_checks++;
    if (!ok) $display("FAIL rresp_done: pending done=%0d, required 0", exp_done_q.size()); else n_pass++;
    n_checks++;
    if (rd_err !== 1'b1) $display("FAIL rd_err_set: got %b, required 1", rd_err); else n_pass++;
  endtask

  task automatic test_short_burst();
    bit ok;
    int tag;
    tag = next_tag++;
    short_beats = 10;
    exp_ar_q.push_back('{27'h1000, 8'd15});
    exp_ar_q.push_back('{27'h1050, 8'd9});
    for (int i = 0; i < 20; i++) exp_beat_q.push_back('{beat_data(27'h1000 + AW'(8 * i)), tag});
    exp_done_q.push_back(tag);
    issue(27'h1000, 20);
    wait_done(300, ok);
    n_checks++;
    if (!ok || exp_ar_q.size() != 0) $display("FAIL short_burst_done: pending done=%0d ar=%0d, required 0/0", exp_done_q.size(), exp_ar_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int tag;
    tag = next_tag++;
    exp_ar_q.push_back('{27'h7FFFFF8, 8'd2});
    exp_beat_q.push_back('{beat_data(27'h7FFFFF8), tag});
    exp_beat_q.push_back('{beat_data(27'h0000000), tag});
    exp_beat_q.push_back('{beat_data(27'h0000008), tag});
    exp_done_q.push_back(tag);
    issue(27'h7FFFFF8, 3);
    wait_done(100, ok);
    n_checks++;
    if (!ok) $display("FAIL wrap_done: pending done=%0d, required 0", exp_done_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    n_checks++;
    if (req_ovf !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", req_ovf); else n_pass++;
    push_req(27'h2000, 5, next_tag++);
    push_req(27'h3000, 18, next_tag++);
    @(negedge ddr_clk);
    ddr_rreq = 1'b1; ddr_raddr = 27'h2000; ddr_rd_len = 16'd5;
    @(negedge ddr_clk);
    ddr_raddr = 27'h3000; ddr_rd_len = 16'd18;
    @(negedge ddr_clk);
    ddr_raddr = 27'h4000; ddr_rd_len = 16'd4;
    @(negedge ddr_clk);
    ddr_rreq = 1'b0;
    wait_done(400, ok);
    repeat (5) @(negedge ddr_clk);
    n_checks++;
    if (!ok || exp_ar_q.size() != 0) $display("FAIL b2b_done: pending done=%0d ar=%0d, required 0/0", exp_done_q.size(), exp_ar_q.size());
    else n_pass++;
    n_checks++;
    if (req_ovf !== 1'b1) $display("FAIL ovf_set: got %b, required 1", req_ovf); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    bit ok, quiet;
    ok = 1'b0; quiet = 1'b1;
    push_req(27'h300, 16, next_tag++);
    issue(27'h300, 16);
    for (int i = 0; i < 200; i++) begin
      @(negedge ddr_clk); #1;
      if (exp_beat_q.size() <= 9) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL mid_reset_reach: beats left=%0d, required 9", exp_beat_q.size()); else n_pass++;
    mon_en = 1'b0;
    ddr_rst = 1'b1;
    @(negedge ddr_clk); #1;
    n_checks++;
    if ({axi_bus.axi_arvalid, axi_bus.axi_rready, ddr_rdata_en, ddr_rdone, req_ovf, rd_err} !== 6'b0 ||
        ddr_rdata !== '0 || axi_bus.axi_araddr !== '0 || axi_bus.axi_arlen !== 8'd0)
      $display("FAIL mid_reset_outputs: ctrl=%b rdata=%h araddr=%h arlen=%0d, required all 0",
               {axi_bus.axi_arvalid, axi_bus.axi_rready, ddr_rdata_en, ddr_rdone, req_ovf, rd_err},
               ddr_rdata, axi_bus.axi_araddr, axi_bus.axi_arlen);
    else n_pass++;
    ddr_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ddr_clk); #1;
      if (ddr_rdata_en !== 1'b0 || ddr_rdone !== 1'b0 || axi_bus.axi_arvalid !== 1'b0 || axi_bus.axi_rready !== 1'b0)
        quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL mid_reset_abandon: activity after reset, required none"); else n_pass++;
    slave_flush = 1'b1;
    repeat (2) @(negedge ddr_clk);
    #1;
    slave_flush = 1'b0;
    exp_ar_q.delete(); exp_beat_q.delete(); exp_done_q.delete();
    last_rdata = '0;
    mon_en = 1'b1;
    push_req(27'h500, 20, next_tag++);
    issue(27'h500, 20);
    wait_done(300, ok);
    n_checks++;
    if (!ok || exp_ar_q.size() != 0) $display("FAIL post_reset_done: pending done=%0d ar=%0d, required 0/0", exp_done_q.size(), exp_ar_q.size());
    else n_pass++;
  endtask

  initial begin
    axi_bus.axi_arready = 1'b0;
    axi_bus.axi_rvalid  = 1'b0;
    axi_bus.axi_rlast   = 1'b0;
    axi_bus.axi_rresp   = 2'b00;
    axi_bus.axi_rdata   = '0;
    test_reset();
    test_multi_burst();
    test_zero_len();
    test_ar_stall();
    test_rresp_err();
    test_short_burst();
    test_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (3) @(negedge ddr_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
